// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared types and constants for the PS/2 scan-code receive path.
// Prefix bytes, frame length and the buffered key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // start low, stop high, odd parity over data+parity
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
// Head entry is shown while valid; ready pops it.
interface ps2_scancode_receiver_if;

  logic       valid;
  logic       ready;
  logic [7:0] scan_code;
  logic       is_break;
  logic       is_extended;

  modport master (
    output valid,
    output scan_code,
    output is_break,
    output is_extended,
    input  ready
  );

  modport slave (
    input  valid,
    input  scan_code,
    input  is_break,
    input  is_extended,
    output ready
  );

endinterface

// File: rtl/ps2_scancode_receiver_fifo.sv
// First-word-fall-through FIFO of key events.
// A push into a full FIFO is dropped unless a pop frees a slot.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  key_evt_t i_evt,
  input  logic     i_pop,
  output key_evt_t o_head,
  output logic     o_empty,
  output logic     o_wr_ok,
  output logic     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  key_evt_t    r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_pop);

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_wr_ok = w_wr;
  assign o_drop  = i_push && !w_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_evt;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 frame receiver: synchronise, assemble 11-bit frames,
// fold E0/F0 prefixes into flags and buffer key events.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_scancode_receiver_if.master evt,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] key_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;

  logic [3:0]    r_bitcnt;
  logic [9:0]    r_frame;
  logic [TW-1:0] r_idle;
  logic          r_ext;
  logic          r_brk;
  logic          r_push;
  logic          r_err;
  key_evt_t      r_evt;
  logic          r_ovf;
  logic [7:0]    r_kc;

  logic       w_fall;
  logic       w_bit;
  logic       w_last;
  logic       w_good;
  logic [7:0] w_byte;
  logic       w_is_ext;
  logic       w_is_brk;
  key_evt_t   w_head;
  logic       w_empty;
  logic       w_wr_ok;
  logic       w_drop;

  // idle bus is high, so the synchronisers preset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall   = r_clk_prev && !r_clk_sync[SYNC_STAGES-1];
  assign w_bit    = r_dat_sync[SYNC_STAGES-1];
  assign w_last   = (r_bitcnt == 4'(PS2_FRAME_BITS - 1));
  assign w_good   = frame_ok({w_bit, r_frame});
  assign w_byte   = r_frame[8:1];
  assign w_is_ext = w_good && (w_byte == PS2_PREFIX_EXT);
  assign w_is_brk = w_good && (w_byte == PS2_PREFIX_BREAK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_frame  <= '0;
      r_idle   <= '0;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_push   <= 1'b0;
      r_err    <= 1'b0;
      r_evt    <= '0;
    end else begin
      r_push <= 1'b0;
      r_err  <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        if (w_last) begin
          r_bitcnt <= '0;
          unique case (1'b1)
            !w_good: begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
            w_is_ext: r_ext <= 1'b1;
            w_is_brk: r_brk <= 1'b1;
            default: begin
              r_push <= 1'b1;
              r_evt  <= {r_ext, r_brk, w_byte};
              r_ext  <= 1'b0;
              r_brk  <= 1'b0;
            end
          endcase
        end else begin
          r_frame  <= {w_bit, r_frame[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        // stalled mid-frame: abandon it and any pending prefix
        if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bitcnt <= '0;
          r_idle   <= '0;
          r_ext    <= 1'b0;
          r_brk    <= 1'b0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_evt   (r_evt),
    .i_pop   (evt.ready),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_wr_ok (w_wr_ok),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_kc  <= '0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_wr_ok && !r_evt.brk) r_kc <= r_kc + 8'd1;
    end
  end

  assign evt.valid       = !w_empty;
  assign evt.scan_code   = w_head.code;
  assign evt.is_break    = w_head.brk;
  assign evt.is_extended = w_head.extended;
  assign overflow        = r_ovf;
  assign frame_err       = r_err;
  assign key_count       = r_kc;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: table vectors, random frames
// against a queue-based event model, and hand-written corner cases.
module tb_ps2_scancode_receiver;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ready = 1'b0;
  logic       overflow;
  logic       frame_err;
  logic [7:0] key_count;

  ps2_scancode_receiver_if bus ();
  assign bus.ready = ready;

  always #5 clk = ~clk;

  ps2_scancode_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_dat),
    .evt       (bus),
    .overflow  (overflow),
    .frame_err (frame_err),
    .key_count (key_count)
  );

  int checks = 0;
  int failures = 0;

  // reference model: pending events, prefix flags, counters
  logic [9:0] q[$];
  bit         m_ext = 0;
  bit         m_brk = 0;
  bit         m_ovf = 0;
  int         m_kc = 0;
  int         m_err = 0;
  int         err_seen = 0;
  bit         auto_rdy = 0;
  logic [9:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good,
                             input bit simul);
    if (!good) begin
      m_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (q.size() < DEPTH || simul) begin
        q.push_back({m_ext, m_brk, b});
        if (!m_brk) m_kc++;
      end else begin
        m_ovf = 1;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ext = 0;
    m_brk = 0;
    m_ovf = 0;
    m_kc  = 0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
  // mode: 0 plain, 1 pop aligned with push, 2 latency probe
  task automatic send_frame(input logic [7:0] b, input int kind,
                            input int mode);
    logic [10:0] f;
    f[0]    = (kind == 2);
    f[8:1]  = b;
    f[9]    = (~^b) ^ (kind == 1);
    f[10]   = (kind != 3);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_dat = f[10];
    wait_cyc(10);
    ps2_clk = 1'b0;
    model_frame(b, kind == 0, mode == 1);
    if (mode == 1) begin
      repeat (SYNC + 1) @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      wait_cyc(20 - SYNC - 2);
    end else if (mode == 2) begin
      repeat (SYNC + 1) @(posedge clk);
      #1 chk("latency_early", int'(bus.valid), 0);
      @(posedge clk);
      #1 chk("latency_valid", int'(bus.valid), 1);
      wait_cyc(20 - SYNC - 2);
    end else begin
      wait_cyc(20);
    end
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_dat = 1'b1;
  endtask

  task automatic drain();
    ready = 1'b1;
    wait_cyc(24);
    ready = 1'b0;
    chk("drain_model_empty", q.size(), 0);
    chk("drain_valid", int'(bus.valid), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (bus.valid && ready) begin
        if (q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("pop_event",
              int'({bus.is_extended, bus.is_break, bus.scan_code}),
              int'(mon_e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_rdy) ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [7:0] b;
    int         kind;
    bit         ev;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    int         err;
    int         kc;
  } vec_t;

  vec_t tv[15];

  initial begin
    int e0;
    logic [7:0] rb;
    int rk;
    int r;

    tv[0]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1};
    tv[1]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0, 1};
    tv[2]  = '{8'h1C, 0, 1, 8'h1C, 1, 0, 0, 1};
    tv[3]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0, 1};
    tv[4]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0, 1};
    tv[5]  = '{8'h75, 0, 1, 8'h75, 1, 1, 0, 1};
    tv[6]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0, 1};
    tv[7]  = '{8'h1C, 1, 0, 8'h00, 0, 0, 1, 1};
    tv[8]  = '{8'h15, 0, 1, 8'h15, 0, 0, 0, 2};
    tv[9]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0, 2};
    tv[10] = '{8'hE0, 0, 0, 8'h00, 0, 0, 0, 2};
    tv[11] = '{8'h6B, 0, 1, 8'h6B, 0, 1, 0, 3};
    tv[12] = '{8'h22, 2, 0, 8'h00, 0, 0, 1, 3};
    tv[13] = '{8'h22, 3, 0, 8'h00, 0, 0, 1, 3};
    tv[14] = '{8'h4A, 0, 1, 8'h4A, 0, 0, 0, 4};

    #1;
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_key_count", int'(key_count), 0);
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4);
    chk("idle_valid", int'(bus.valid), 0);

    for (int i = 0; i < 15; i++) begin
      e0 = err_seen;
      send_frame(tv[i].b, tv[i].kind, (i == 0) ? 2 : 0);
      chk("vec_valid", int'(bus.valid), int'(tv[i].ev));
      if (tv[i].ev) begin
        chk("vec_code", int'(bus.scan_code), int'(tv[i].code));
        chk("vec_break", int'(bus.is_break), int'(tv[i].brk));
        chk("vec_ext", int'(bus.is_extended), int'(tv[i].ext));
      end
      chk("vec_frame_err", err_seen - e0, tv[i].err);
      chk("vec_key_count", int'(key_count), tv[i].kc);
      if (tv[i].ev) begin
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        chk("vec_popped", int'(bus.valid), 0);
      end
    end

    auto_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) rb = 8'hE0;
      else if (r < 35) rb = 8'hF0;
      else rb = 8'($urandom_range(0, 255));
      rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(rb, rk, 0);
    end
    auto_rdy = 0;
    drain();
    chk("rand_key_count", int'(key_count), m_kc % 256);
    chk("rand_overflow", int'(overflow), int'(m_ovf));
    chk("rand_frame_err", err_seen, m_err);

    // stalled partial frame after a break prefix
    send_frame(8'hF0, 0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    m_ext = 0;
    m_brk = 0;
    wait_cyc(TMO + 1);
    send_frame(8'h2A, 0, 0);
    chk("timeout_valid", int'(bus.valid), 1);
    chk("timeout_code", int'(bus.scan_code), 'h2A);
    chk("timeout_break", int'(bus.is_break), 0);
    chk("timeout_no_err", err_seen, m_err);

    // reset in the middle of a frame with an event queued
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", int'(bus.valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_key_count", int'(key_count), 0);
    ps2_dat = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);

    for (int b = 1; b <= 9; b++) send_frame(8'(b), 0, 0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_key_count", int'(key_count), 8);
    drain();
    chk("ovf_sticky", int'(overflow), 1);

    wait_cyc(1);
    rst = 1'b1;
    model_reset();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    chk("rst_clears_ovf", int'(overflow), 0);

    for (int b = 'h30; b < 'h38; b++) send_frame(8'(b), 0, 0);
    ready = 1'b1;
    wait_cyc(3);
    ready = 1'b0;
    for (int b = 'h38; b < 'h3B; b++) send_frame(8'(b), 0, 0);
    send_frame(8'h3B, 0, 1);
    chk("pushpop_overflow", int'(overflow), 0);
    chk("pushpop_key_count", int'(key_count), 12);
    chk("pushpop_valid", int'(bus.valid), 1);
    drain();
    chk("final_frame_err", err_seen, m_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
